// File: rtl/m_seq_checker_if.sv
// Serial PN input and checker status bundle for m_seq_checker.
interface m_seq_checker_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             in_valid;
  logic             m_in;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  // Source side: drives the bitstream, observes checker status
  modport master (
    output in_valid, m_in,
    input  locked, err, err_cnt, bit_cnt
  );

  // Checker side
  modport slave (
    input  in_valid, m_in,
    output locked, err, err_cnt, bit_cnt
  );
endinterface

// File: rtl/m_seq_checker.sv
// PN bitstream checker: self-synchronises a local LFSR, locks, then counts bit errors.
module m_seq_checker #(
  parameter int unsigned    N        = 7,
  parameter logic [N-1:0]   TAPS     = 7'b1100000,
  parameter int unsigned    LOCK_CNT = 16,
  parameter int unsigned    WIN      = 128,
  parameter int unsigned    ERR_TH   = 8,
  parameter int unsigned    CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  m_seq_checker_if.slave  bus
);

  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WB_W   = $clog2(WIN + 1);
  localparam int unsigned WE_W   = $clog2(ERR_TH + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [WB_W-1:0]    wb_q, wb_d;
  logic [WE_W-1:0]    we_q, we_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic               pred_c;
  logic               miss_c;
  logic [FILL_W-1:0]  fill_inc_c;
  logic [RUN_W-1:0]   run_inc_c;
  logic [WB_W-1:0]    wb_inc_c;
  logic [WE_W-1:0]    we_next_c;

  // Local prediction and incremented counter values
  assign pred_c     = ^(sr_q & TAPS);
  assign miss_c     = (bus.m_in != pred_c);
  assign fill_inc_c = fill_q + FILL_W'(1);
  assign run_inc_c  = run_q + RUN_W'(1);
  assign wb_inc_c   = wb_q + WB_W'(1);
  assign we_next_c  = miss_c ? (we_q + WE_W'(1)) : we_q;

  // Next-state and datapath update; only valid bits advance anything
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    run_d     = run_q;
    wb_d      = wb_q;
    we_d      = we_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          sr_d   = {sr_q[N-2:0], bus.m_in};
          fill_d = fill_inc_c;
          if (fill_inc_c == FILL_W'(N)) begin
            state_d = SYNC;
            run_d   = '0;
          end
        end
        SYNC: begin
          sr_d = {sr_q[N-2:0], bus.m_in};
          // All-zero register predicts zero forever; never count it as a match
          if (!miss_c && (sr_q != '0)) begin
            run_d = run_inc_c;
            if (run_inc_c == RUN_W'(LOCK_CNT)) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              err_cnt_d = '0;
              bit_cnt_d = '0;
              wb_d      = '0;
              we_d      = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one bad bit is counted once
          sr_d = {sr_q[N-2:0], pred_c};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (miss_c) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (we_next_c >= WE_W'(ERR_TH)) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            fill_d   = '0;
            run_d    = '0;
            sr_d     = '0;
          end else if (wb_inc_c == WB_W'(WIN)) begin
            wb_d = '0;
            we_d = '0;
          end else begin
            wb_d = wb_inc_c;
            we_d = we_next_c;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      fill_q    <= '0;
      run_q     <= '0;
      wb_q      <= '0;
      we_q      <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      run_q     <= run_d;
      wb_q      <= wb_d;
      we_q      <= we_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_m_seq_checker.sv
// Bench for m_seq_checker: random PN7 streams with planted errors versus a bit-level reference model.
module tb_m_seq_checker;

  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst;

  m_seq_checker_if #(.CNT_W(CNT_W)) bus ();

  m_seq_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: tracks the last 7 reference bits as a plain history queue
  bit             ref_q[$];
  int             m_mode;
  int             m_fill, m_run, m_wb, m_we;
  bit             m_locked, m_err;
  logic [15:0]    m_err_cnt, m_bit_cnt;

  // PN7 source: b[k] = b[k-7] ^ b[k-6]
  bit             pn_h[$];
  bit             fl[256];

  function automatic void model_reset();
    ref_q.delete();
    for (int i = 0; i < 7; i++) ref_q.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_wb = 0; m_we = 0;
    m_locked = 0; m_err = 0; m_err_cnt = '0; m_bit_cnt = '0;
  endfunction

  function automatic void model_step(input bit v, input bit b);
    bit pred;
    bit nz;
    m_err = 0;
    if (!v) return;
    pred = ref_q[0] ^ ref_q[1];
    nz = 0;
    foreach (ref_q[i]) nz |= ref_q[i];
    case (m_mode)
      0: begin
        ref_q.push_back(b); void'(ref_q.pop_front());
        m_fill++;
        if (m_fill == 7) begin m_mode = 1; m_run = 0; end
      end
      1: begin
        ref_q.push_back(b); void'(ref_q.pop_front());
        if (b == pred && nz) m_run++; else m_run = 0;
        if (m_run == 16) begin
          m_mode = 2; m_locked = 1; m_err_cnt = '0; m_bit_cnt = '0; m_wb = 0; m_we = 0;
        end
      end
      default: begin
        ref_q.push_back(pred); void'(ref_q.pop_front());
        if (m_bit_cnt != 16'hFFFF) m_bit_cnt++;
        m_wb++;
        if (b != pred) begin
          m_err = 1;
          if (m_err_cnt != 16'hFFFF) m_err_cnt++;
          m_we++;
        end
        if (m_we >= 8) begin
          m_mode = 0; m_locked = 0; m_fill = 0; m_run = 0;
          foreach (ref_q[i]) ref_q[i] = 1'b0;
        end else if (m_wb == 128) begin
          m_wb = 0; m_we = 0;
        end
      end
    endcase
  endfunction

  function automatic void pn_seed();
    logic [6:0] s;
    s = 7'($urandom_range(1, 127));
    pn_h.delete();
    for (int i = 0; i < 7; i++) pn_h.push_back(s[i]);
  endfunction

  function automatic bit pn_next();
    bit nb;
    nb = pn_h[0] ^ pn_h[1];
    pn_h.push_back(nb);
    void'(pn_h.pop_front());
    return nb;
  endfunction

  function automatic void clear_fl();
    foreach (fl[i]) fl[i] = 1'b0;
  endfunction

  // Marks n distinct random positions in [lo,hi] for inversion
  function automatic void pick(input int n, input int lo, input int hi);
    int k;
    int idx;
    k = 0;
    while (k < n) begin
      idx = int'($urandom_range(hi, lo));
      if (!fl[idx]) begin fl[idx] = 1'b1; k++; end
    end
  endfunction

  task automatic step(input bit v, input bit b);
    @(negedge clk);
    bus.in_valid = v;
    bus.m_in     = b;
    @(posedge clk);
    model_step(v, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.m_in     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pn_seed();
  endtask

  // Feeds 23 clean bits and checks lock arrives on exactly the 23rd
  task automatic lock_up(input string tag);
    for (int i = 1; i <= 23; i++) begin
      step(1'b1, pn_next());
      if (i >= 22) begin
        checks++;
        if (bus.locked !== (i == 23))
          $display("FAIL %s_lock_bit%0d: locked=%b, required %b", tag, i, bus.locked, (i == 23));
        else passed++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.m_in = 1'b0;
    model_reset();
    pn_seed();
    #3;
    checks++;
    if ({bus.locked, bus.err} !== 2'b00)
      $display("FAIL reset_flags: locked/err=%b%b, required 00", bus.locked, bus.err);
    else passed++;
    checks++;
    if (bus.err_cnt !== '0) $display("FAIL reset_err_cnt: got %0d, required 0", bus.err_cnt);
    else passed++;
    checks++;
    if (bus.bit_cnt !== '0) $display("FAIL reset_bit_cnt: got %0d, required 0", bus.bit_cnt);
    else passed++;
  endtask

  task automatic test_clean_lock();
    int pulses;
    do_reset();
    lock_up("clean");
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, pn_next());
      if (bus.err) pulses++;
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL clean_model bit %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if (bus.err_cnt !== 16'd0) $display("FAIL clean_err_cnt: got %0d, required 0", bus.err_cnt);
    else passed++;
    checks++;
    if (bus.bit_cnt !== 16'd1000) $display("FAIL clean_bit_cnt: got %0d, required 1000", bus.bit_cnt);
    else passed++;
    checks++;
    if (pulses != 0) $display("FAIL clean_err_pulses: got %0d, required 0", pulses);
    else passed++;
  endtask

  task automatic test_single_error();
    int pulses;
    int at;
    at = int'($urandom_range(90, 10));
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, pn_next() ^ (i == at));
      if (bus.err) pulses++;
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL single_model bit %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if (pulses != 1) $display("FAIL single_pulses: got %0d, required 1", pulses);
    else passed++;
    checks++;
    if (bus.err_cnt !== 16'd1) $display("FAIL single_err_cnt: got %0d, required 1", bus.err_cnt);
    else passed++;
    checks++;
    if (bus.locked !== 1'b1) $display("FAIL single_locked: got %b, required 1", bus.locked);
    else passed++;
  endtask

  task automatic test_loss_of_lock();
    int pulses;
    int last;
    do_reset();
    lock_up("loss");
    clear_fl();
    pick(8, 0, 127);
    last = 0;
    for (int i = 0; i < 128; i++) if (fl[i]) last = i;
    pulses = 0;
    for (int i = 0; i <= last; i++) begin
      step(1'b1, pn_next() ^ fl[i]);
      if (bus.err) pulses++;
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL loss_model bit %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if (pulses != 8) $display("FAIL loss_pulses: got %0d, required 8", pulses);
    else passed++;
    checks++;
    if (bus.locked !== 1'b0) $display("FAIL loss_locked: got %b, required 0", bus.locked);
    else passed++;
    checks++;
    if (bus.err_cnt !== 16'd8) $display("FAIL loss_err_cnt_hold: got %0d, required 8", bus.err_cnt);
    else passed++;
    checks++;
    if (bus.bit_cnt !== 16'(last + 1))
      $display("FAIL loss_bit_cnt_hold: got %0d, required %0d", bus.bit_cnt, last + 1);
    else passed++;
    lock_up("relock");
    checks++;
    if ({bus.err_cnt, bus.bit_cnt} !== 32'd0)
      $display("FAIL relock_counts: got ec=%0d bc=%0d, required 0 0", bus.err_cnt, bus.bit_cnt);
    else passed++;
  endtask

  task automatic test_window_reset();
    int pulses;
    do_reset();
    lock_up("win");
    clear_fl();
    pick(7, 100, 127);
    pick(7, 128, 160);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, pn_next() ^ fl[i]);
      if (bus.err) pulses++;
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL win_model bit %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if (bus.locked !== 1'b1) $display("FAIL win_locked: got %b, required 1", bus.locked);
    else passed++;
    checks++;
    if (bus.err_cnt !== 16'd14) $display("FAIL win_err_cnt: got %0d, required 14", bus.err_cnt);
    else passed++;
    checks++;
    if (pulses != 14) $display("FAIL win_pulses: got %0d, required 14", pulses);
    else passed++;
  endtask

  task automatic test_degenerate_gapped();
    int lock_seen;
    int k;
    bit v;
    do_reset();
    lock_seen = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0);
      if (bus.locked) lock_seen++;
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL zero_model cyc %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if (lock_seen != 0) $display("FAIL zero_never_locks: locked cycles %0d, required 0", lock_seen);
    else passed++;

    do_reset();
    k = 0;
    for (int c = 0; c < 3 * 1023; c++) begin
      v = ((c % 3) == 2);
      step(v, v ? pn_next() : 1'($urandom));
      if (v) k++;
      if (v && (k == 22 || k == 23)) begin
        checks++;
        if (bus.locked !== (k == 23))
          $display("FAIL gap_lock_bit%0d: locked=%b, required %b", k, bus.locked, (k == 23));
        else passed++;
      end
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL gap_model cyc %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 c, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if ({bus.err_cnt, bus.bit_cnt} !== {16'd0, 16'd1000})
      $display("FAIL gap_counts: got ec=%0d bc=%0d, required 0 1000", bus.err_cnt, bus.bit_cnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_up("arst");
    clear_fl();
    pick(2, 0, 99);
    fl[119] = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step(1'b1, pn_next() ^ fl[i]);
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt, bus.bit_cnt} !== {m_locked, m_err, m_err_cnt, m_bit_cnt})
        $display("FAIL arst_model bit %0d: got l=%b e=%b ec=%0d bc=%0d, required l=%b e=%b ec=%0d bc=%0d",
                 i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
      else passed++;
    end
    checks++;
    if ({bus.locked, bus.err, bus.err_cnt} !== {2'b11, 16'd3})
      $display("FAIL arst_pre: got l=%b e=%b ec=%0d, required l=1 e=1 ec=3", bus.locked, bus.err, bus.err_cnt);
    else passed++;
    // Assert reset between clock edges and look before the next rising edge
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.m_in = pn_next();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.locked, bus.err} !== 2'b00)
      $display("FAIL arst_flags: got l=%b e=%b, required 0 0", bus.locked, bus.err);
    else passed++;
    checks++;
    if ({bus.err_cnt, bus.bit_cnt} !== 32'd0)
      $display("FAIL arst_counts: got ec=%0d bc=%0d, required 0 0", bus.err_cnt, bus.bit_cnt);
    else passed++;
    model_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    lock_up("arst_relock");
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_window_reset();
    test_degenerate_gapped();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/m_seq_checker.md
Name: m_seq_checker

Overview:
- Downstream consumer of the m-sequence generator's serial output `m`.
- Self-synchronises a local LFSR to the incoming PN bitstream, declares lock, then counts bit errors against the free-running local reference.
- Drops lock when the error density gets too high.
- Used for link/BER checking of PN test patterns.

Parameters:
- N, 7, LFSR order; width of the shift register.
- TAPS, 7'b1100000, feedback mask (N bits). Predicted bit = XOR of sr bits where TAPS=1. Default is x^7+x^6+1.
- LOCK_CNT, 16, consecutive correct predictions in SYNC required to declare lock (≥1).
- WIN, 128, window length in valid bits for the loss-of-lock check.
- ERR_TH, 8, errors within one window that force loss of lock (1..WIN).
- CNT_W, 16, width of err_cnt and bit_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  m_in is sampled only when high; may have arbitrary gaps.
- m_in  in  1  received PN bit.
- locked  out  1  high while in LOCKED state.
- err  out  1  one-cycle pulse per mismatching bit while LOCKED.
- err_cnt  out  CNT_W  errors since the last lock acquisition; saturating.
- bit_cnt  out  CNT_W  bits checked since the last lock acquisition; saturating.

Behaviour:
- **Reset (async, rst=1):**
  - state=HUNT; sr, fill count, run count, window counters all 0.
  - locked=0, err=0, err_cnt=0, bit_cnt=0.
  - Takes effect immediately, including mid-lock.
- **Core logic:**
  - sr shifts in the new bit as `sr <= {sr[N-2:0], bit}`; sr[0] is newest.
  - pred = ^(sr & TAPS).
  - Nothing changes on cycles with in_valid=0, except err returns to 0.
- **HUNT:**
  - Each valid bit: shift m_in into sr and increment the fill count.
  - After the N-th valid bit: go to SYNC with run=0.
- **SYNC:**
  - Each valid bit: compare m_in with pred, then shift m_in into sr (self-synchronising).
  - Match with sr≠0: run++.
  - Mismatch, or sr==0: run=0. The all-zero lockup is rejected, so a constant-0 input never locks.
  - When run reaches LOCK_CNT: go to LOCKED. In the same edge, clear err_cnt, bit_cnt, window bit count and window error count.
  - locked becomes 1 on the clock edge that consumes the LOCK_CNT-th match, i.e. it is visible in the following cycle.
- **LOCKED:**
  - Each valid bit: shift pred (not m_in) into sr, so the local generator free-runs and errors are counted once, without multiplication.
  - bit_cnt++ (saturating).
  - If m_in≠pred: err=1 for one cycle (registered, same edge), err_cnt++ (saturating), window error count++.
  - Window bit count increments per valid bit.
  - Loss of lock: if the window error count including the current bit reaches ERR_TH, go to HUNT.
    - Clear locked, fill count, run and sr.
    - err still pulses for that bit; err_cnt and bit_cnt hold their values until the next lock.
  - Window end: on reaching WIN bits, the window count wraps to 0 and the window error count clears.
  - Priority: the loss-of-lock check is evaluated before the window clear on the same bit.
- **Counters:** saturate at 2^CNT_W−1; they never wrap.
- **Latency:** all outputs are registered; responses appear in the cycle after the sampling edge.

Test Plan:
1. **Clean lock:** continuous PN7 (x^7+x^6+1), in_valid=1 from the first cycle after reset release.
   - locked rises after the edge consuming valid bit 23 (7 fill + 16 match).
   - After 1000 further bits: err_cnt=0, bit_cnt=1000, err never pulsed.
2. **Single error:** while locked, invert one bit.
   - Exactly one err pulse; err_cnt=1; locked stays 1.
   - Subsequent bits are error-free, confirming no error multiplication.
3. **Loss of lock:** while locked, invert 8 bits within one 128-bit window.
   - err pulses 8 times; locked falls after the edge of the 8th error; err_cnt holds 8.
   - Clean stream resumes: relock after 23 more valid bits, with err_cnt and bit_cnt cleared to 0.
4. **Window reset:** invert 7 bits in window 1 and 7 bits in window 2, with window-relative positions spanning the boundary.
   - locked stays 1; err_cnt=14.
5. **Degenerate and gapped input:**
   - 500 cycles of m_in=0 with in_valid=1: locked never asserts.
   - PN7 with in_valid high every 3rd cycle: lock after 23 valid bits (about 69 cycles); counts match scenario 1.
6. **Async reset mid-lock:** assert rst between clock edges while locked with err_cnt=3.
   - locked, err, err_cnt, bit_cnt go to 0 immediately, without waiting for a clock edge.
   - After release: normal relock as in scenario 1.
